// File: rtl/cpu_types_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_types_pkg : shared types and constants for the L1 data cache         |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
package cpu_types_pkg;

  localparam int DC_SETS  = 8;
  localparam int DC_IDX_W = $clog2(DC_SETS);
  localparam int DC_TAG_W = 32 - 3 - DC_IDX_W;

  typedef struct packed {
    logic                valid;
    logic                dirty;
    logic [DC_TAG_W-1:0] tag;
    logic [1:0][31:0]    data;
  } dcache_frame_t;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    WB0    = 4'd1,
    WB1    = 4'd2,
    LD0    = 4'd3,
    LD1    = 4'd4,
    FLUSH  = 4'd5,
    FWB0   = 4'd6,
    FWB1   = 4'd7,
    HALTED = 4'd8
  } dcache_state_t;

endpackage
`default_nettype wire

// File: rtl/dcache_way.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dcache_way : one way of the data cache; SETS frames, lookup + write port |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module dcache_way
  import cpu_types_pkg::*;
#(
  parameter int SETS  = DC_SETS,
  parameter int IDX_W = $clog2(SETS)
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [IDX_W-1:0]    idx_i,
  input  logic [DC_TAG_W-1:0] tag_i,
  input  logic                blk_i,
  output logic                hit_o,
  output logic [31:0]         word_o,
  output dcache_frame_t       frame_o,
  input  logic                store_i,
  input  logic [31:0]         wdata_i,
  input  logic                fill_i,
  input  dcache_frame_t       fill_frame_i,
  input  logic                clean_i
);

  dcache_frame_t frames_q [SETS];

  assign frame_o = frames_q[idx_i];
  assign hit_o   = frame_o.valid && (frame_o.tag == tag_i);
  assign word_o  = frame_o.data[blk_i];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int s = 0; s < SETS; s++) begin
        frames_q[s] <= '0;
      end
    end else if (fill_i) begin
      frames_q[idx_i] <= fill_frame_i;
    end else if (store_i) begin
      frames_q[idx_i].data[blk_i] <= wdata_i;
      frames_q[idx_i].dirty       <= 1'b1;
    end else if (clean_i) begin
      frames_q[idx_i].dirty <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dcache_llsc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dcache_llsc : 2-way write-back L1 data cache with LL/SC link and flush   |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module dcache_llsc
  import cpu_types_pkg::*;
#(
  parameter int SETS  = DC_SETS,
  parameter int WORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic        datomic,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait
);

  localparam int IDX_W   = $clog2(SETS);
  localparam int OFF_LSB = $clog2(WORDS) + 2;
  localparam int CNT_W   = IDX_W + 1;

  dcache_state_t state_q, state_d;

  logic [SETS-1:0]     lru_q;
  logic                link_valid_q;
  logic [31:0]         link_addr_q;
  logic                miss_way_q;
  logic [31:0]         fill_word_q;
  logic [CNT_W-1:0]    flush_cnt_q;

  logic [DC_TAG_W-1:0] req_tag;
  logic [IDX_W-1:0]    req_idx;
  logic                req_blk;
  logic                is_write, is_load, is_req, is_ll, is_sc;
  logic                link_match, sc_fail, hit_any, hit_way, victim_way, hit_ev;
  logic                flushing, flush_last, flush_adv, flush_way, sel_way;
  logic [IDX_W-1:0]    flush_idx, way_idx;
  dcache_frame_t       victim_frame, sel_frame, fill_frame;

  logic [1:0]          way_hit, way_store, way_fill, way_clean;
  logic [31:0]         way_word  [2];
  dcache_frame_t       way_frame [2];

  assign req_tag = dmemaddr[31:OFF_LSB+IDX_W];
  assign req_idx = dmemaddr[OFF_LSB+IDX_W-1:OFF_LSB];
  assign req_blk = dmemaddr[2];

  // A simultaneous REN+WEN is resolved as a write.
  assign is_write   = dmemWEN;
  assign is_load    = dmemREN & ~dmemWEN;
  assign is_req     = dmemREN | dmemWEN;
  assign is_ll      = is_load & datomic;
  assign is_sc      = is_write & datomic;
  assign link_match = link_valid_q && (link_addr_q == dmemaddr);
  assign sc_fail    = is_sc & ~link_match;
  assign hit_any    = |way_hit;
  assign hit_way    = way_hit[1];
  assign victim_way = lru_q[req_idx];
  assign hit_ev     = (state_q == IDLE) && !halt && is_req && !sc_fail && hit_any;

  assign flushing   = (state_q == FLUSH) || (state_q == FWB0) || (state_q == FWB1);
  assign flush_way  = flush_cnt_q[0];
  assign flush_idx  = flush_cnt_q[CNT_W-1:1];
  assign flush_last = &flush_cnt_q;
  assign way_idx    = flushing ? flush_idx : req_idx;
  assign sel_way    = flushing ? flush_way : miss_way_q;

  assign victim_frame = way_frame[victim_way];
  assign sel_frame    = way_frame[sel_way];
  assign flush_adv    = ((state_q == FLUSH) && !(sel_frame.valid && sel_frame.dirty)) ||
                        ((state_q == FWB1) && !dwait);

  for (genvar w = 0; w < 2; w++) begin : g_way
    dcache_way #(
      .SETS  (SETS),
      .IDX_W (IDX_W)
    ) u_way (
      .CLK          (CLK),
      .nRST         (nRST),
      .idx_i        (way_idx),
      .tag_i        (req_tag),
      .blk_i        (req_blk),
      .hit_o        (way_hit[w]),
      .word_o       (way_word[w]),
      .frame_o      (way_frame[w]),
      .store_i      (way_store[w]),
      .wdata_i      (dmemstore),
      .fill_i       (way_fill[w]),
      .fill_frame_i (fill_frame),
      .clean_i      (way_clean[w])
    );
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (halt) begin
          state_d = FLUSH;
        end else if (is_req && !sc_fail && !hit_any) begin
          state_d = (victim_frame.valid && victim_frame.dirty) ? WB0 : LD0;
        end
      end
      WB0:    if (!dwait) state_d = WB1;
      WB1:    if (!dwait) state_d = LD0;
      LD0:    if (!dwait) state_d = LD1;
      LD1:    if (!dwait) state_d = IDLE;
      FLUSH: begin
        if (sel_frame.valid && sel_frame.dirty) begin
          state_d = FWB0;
        end else if (flush_last) begin
          state_d = HALTED;
        end
      end
      FWB0:   if (!dwait) state_d = FWB1;
      FWB1:   if (!dwait) state_d = flush_last ? HALTED : FLUSH;
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dhit       = 1'b0;
    dmemload   = '0;
    dREN       = 1'b0;
    dWEN       = 1'b0;
    daddr      = '0;
    dstore     = '0;
    flushed    = 1'b0;
    way_store  = '0;
    way_fill   = '0;
    way_clean  = '0;
    fill_frame = '0;
    case (state_q)
      IDLE: begin
        if (!halt && is_req) begin
          if (sc_fail) begin
            dhit = 1'b1;
          end else if (hit_any) begin
            dhit = 1'b1;
            if (is_write) begin
              way_store[hit_way] = 1'b1;
              dmemload           = {31'b0, is_sc};
            end else begin
              dmemload = way_word[hit_way];
            end
          end
        end
      end
      WB0, WB1: begin
        dWEN   = 1'b1;
        daddr  = {sel_frame.tag, req_idx, state_q == WB1, 2'b00};
        dstore = sel_frame.data[state_q == WB1];
      end
      LD0, LD1: begin
        dREN  = 1'b1;
        daddr = {req_tag, req_idx, state_q == LD1, 2'b00};
        // The whole frame is written at once so an aborted fill leaves no trace.
        if ((state_q == LD1) && !dwait) begin
          way_fill[sel_way]  = 1'b1;
          fill_frame.valid   = 1'b1;
          fill_frame.dirty   = 1'b0;
          fill_frame.tag     = req_tag;
          fill_frame.data[0] = fill_word_q;
          fill_frame.data[1] = dload;
        end
      end
      FWB0, FWB1: begin
        dWEN   = 1'b1;
        daddr  = {sel_frame.tag, flush_idx, state_q == FWB1, 2'b00};
        dstore = sel_frame.data[state_q == FWB1];
        if ((state_q == FWB1) && !dwait) begin
          way_clean[sel_way] = 1'b1;
        end
      end
      HALTED: flushed = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      lru_q        <= '0;
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
      miss_way_q   <= 1'b0;
      fill_word_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (hit_ev) begin
        lru_q[req_idx] <= ~hit_way;
        if (is_ll) begin
          link_addr_q  <= dmemaddr;
          link_valid_q <= 1'b1;
        end else if (is_write && link_match) begin
          link_valid_q <= 1'b0;
        end
      end
      if (state_q == IDLE) begin
        miss_way_q <= victim_way;
      end
      if ((state_q == LD0) && !dwait) begin
        fill_word_q <= dload;
      end
      if (flush_adv && !flush_last) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
